// File: rtl/serializer.sv
// -----------------------------------------------------------------------------
// serializer
//   Parallel-to-serial converter. Accepts one DATA_W-bit word and shifts it out
//   MSB first, one bit per clock, with a per-bit valid strobe. A request can
//   ask for only the top data_mod_i bits of the word (0 = full word).
//
// Ports
//   clk_i          : clock, rising edge
//   srst_i         : synchronous reset, active low
//   data_i         : parallel word to send
//   data_mod_i     : number of bits to send from the MSB down (0 = DATA_W)
//   data_val_i     : request strobe for data_i / data_mod_i
//   ser_data_o     : serial bit (0 whenever ser_data_val_o is 0)
//   ser_data_val_o : serial bit valid
//   busy_o         : word in flight; requests are dropped while high
// -----------------------------------------------------------------------------
module serializer #(
    parameter  int DATA_W = 16,
    localparam int MOD_W  = $clog2(DATA_W)
) (
    input  logic              clk_i,
    input  logic              srst_i,
    input  logic [DATA_W-1:0] data_i,
    input  logic [MOD_W-1:0]  data_mod_i,
    input  logic              data_val_i,
    output logic              ser_data_o,
    output logic              ser_data_val_o,
    output logic              busy_o
);

    typedef enum logic {IDLE, SEND} state_t;

    // One extra bit so a full-word length (DATA_W) fits in the counter.
    localparam logic [MOD_W:0] FULL_LEN = (MOD_W+1)'(DATA_W);

    state_t            state;
    logic [DATA_W-1:0] shreg;   // bits still to be sent, next one at MSB
    logic [MOD_W:0]    cnt;     // bits remaining, including the one on the wire
    logic [MOD_W:0]    req_len;
    logic              req_ok;

    // Lengths 1 and 2 are not supported and the request is dropped outright.
    always_comb begin
        req_len = (data_mod_i == '0) ? FULL_LEN : {1'b0, data_mod_i};
        req_ok  = data_val_i
               && (data_mod_i != MOD_W'(1))
               && (data_mod_i != MOD_W'(2));
    end

    always_ff @(posedge clk_i) begin
        if (!srst_i) begin
            state          <= IDLE;
            shreg          <= '0;
            cnt            <= '0;
            ser_data_o     <= 1'b0;
            ser_data_val_o <= 1'b0;
            busy_o         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (req_ok) begin
                        // The MSB goes straight to the output register so
                        // it is on the wire the cycle after the accept.
                        state          <= SEND;
                        ser_data_o     <= data_i[DATA_W-1];
                        ser_data_val_o <= 1'b1;
                        busy_o         <= 1'b1;
                        shreg          <= data_i << 1;
                        cnt            <= req_len;
                    end
                end
                SEND: begin
                    if (cnt == (MOD_W+1)'(1)) begin
                        // Last bit was on the wire this cycle; the forced
                        // idle cycle that follows marks the word boundary.
                        state          <= IDLE;
                        ser_data_o     <= 1'b0;
                        ser_data_val_o <= 1'b0;
                        busy_o         <= 1'b0;
                        shreg          <= '0;
                        cnt            <= '0;
                    end else begin
                        ser_data_o <= shreg[DATA_W-1];
                        shreg      <= shreg << 1;
                        cnt        <= cnt - 1'b1;
                    end
                end
                default: begin
                    state          <= IDLE;
                    ser_data_o     <= 1'b0;
                    ser_data_val_o <= 1'b0;
                    busy_o         <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serializer.sv
module tb_serializer;

    logic        clk_i = 1'b0;
    logic        srst_i;
    logic [15:0] data_i;
    logic [3:0]  data_mod_i;
    logic        data_val_i;
    logic        ser_data_o;
    logic        ser_data_val_o;
    logic        busy_o;

    int checks   = 0;
    int failures = 0;

    serializer #(.DATA_W(16)) dut (
        .clk_i          (clk_i),
        .srst_i         (srst_i),
        .data_i         (data_i),
        .data_mod_i     (data_mod_i),
        .data_val_i     (data_val_i),
        .ser_data_o     (ser_data_o),
        .ser_data_val_o (ser_data_val_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h @%0t", tag, got, exp, $time);
        end
    endtask

    // Present a request now; it is taken on the next rising edge.
    task automatic pulse(input logic [15:0] d, input logic [3:0] m);
        data_i     = d;
        data_mod_i = m;
        data_val_i = 1'b1;
        @(posedge clk_i);
        #1 data_val_i = 1'b0;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_val"},  ser_data_val_o, 1'b0);
        chk({tag, "_busy"}, busy_o,         1'b0);
        chk({tag, "_dat"},  ser_data_o,     1'b0);
    endtask

    // Called just after the accept edge: checks len consecutive bit cycles.
    task automatic chk_stream(input string tag, input logic [15:0] w, input int len);
        for (int k = 0; k < len; k++) begin
            @(negedge clk_i);
            chk($sformatf("%s_val%0d", tag, k), ser_data_val_o, 1'b1);
            chk($sformatf("%s_bit%0d", tag, k), ser_data_o,     w[15-k]);
            chk($sformatf("%s_bsy%0d", tag, k), busy_o,         1'b1);
        end
    endtask

    // Behavioural receiver: collects bits, closes a word on the idle gap.
    logic        lb_en = 1'b0;
    logic [15:0] lb_acc;
    int          lb_n = 0;
    logic [15:0] lb_q[$];
    int          lb_nq[$];

    always @(negedge clk_i) begin
        if (lb_en) begin
            if (ser_data_val_o) begin
                lb_acc = {lb_acc[14:0], ser_data_o};
                lb_n++;
            end else if (lb_n > 0) begin
                lb_q.push_back(lb_acc);
                lb_nq.push_back(lb_n);
                lb_n = 0;
            end
        end
    end

    logic [15:0] sent[100];

    initial begin
        srst_i     = 1'b0;
        data_i     = '0;
        data_mod_i = '0;
        data_val_i = 1'b0;

        // Reset, then idle
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk_idle("rst");
        end
        srst_i = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk_idle("idle");
        end

        // Full word
        pulse(16'hA5C3, 4'd0);
        chk_stream("full", 16'hA5C3, 16);
        @(negedge clk_i);
        chk_idle("full_end");

        // Partial word, top 5 bits: 1,1,1,1,0
        @(negedge clk_i);
        pulse(16'hF0FF, 4'd5);
        chk_stream("part", 16'hF0FF, 5);
        @(negedge clk_i);
        chk_idle("part_end");

        // Unsupported lengths are dropped
        @(negedge clk_i);
        pulse(16'hFFFF, 4'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            chk_idle("mod2");
        end
        pulse(16'hFFFF, 4'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk_i);
            chk_idle("mod1");
        end

        // Backpressure: request during bit 3 must not disturb the word
        pulse(16'h1234, 4'd0);
        for (int k = 0; k < 16; k++) begin
            @(negedge clk_i);
            chk($sformatf("bp_val%0d", k), ser_data_val_o, 1'b1);
            chk($sformatf("bp_bit%0d", k), ser_data_o,     logic'(16'h1234 >> (15-k)));
            if (k == 3) begin
                data_i     = 16'hFFFF;
                data_mod_i = 4'd0;
                data_val_i = 1'b1;
            end else if (k == 4) begin
                data_val_i = 1'b0;
            end
        end
        @(negedge clk_i);
        chk_idle("bp_gap");
        // Re-request in the single idle cycle
        pulse(16'hFFFF, 4'd0);
        chk_stream("ones", 16'hFFFF, 16);
        @(negedge clk_i);
        chk_idle("ones_end");

        // Reset in the middle of a word
        @(negedge clk_i);
        pulse(16'hBEEF, 4'd0);
        chk_stream("beef", 16'hBEEF, 7);
        srst_i = 1'b0;
        @(negedge clk_i);
        chk_idle("mid_rst");
        srst_i = 1'b1;
        @(negedge clk_i);
        chk_idle("post_rst");
        pulse(16'h0001, 4'd0);
        chk_stream("one", 16'h0001, 16);
        @(negedge clk_i);
        chk_idle("one_end");

        // Loopback: 100 random words, as fast as busy_o allows
        lb_en = 1'b1;
        for (int i = 0; i < 100; i++) begin
            int t;
            t = 0;
            @(negedge clk_i);
            while (busy_o && t < 40) begin
                @(negedge clk_i);
                t++;
            end
            chk("lb_wait", busy_o, 1'b0);
            sent[i] = 16'($urandom);
            pulse(sent[i], 4'd0);
        end
        repeat (20) @(negedge clk_i);
        chk("lb_cnt", lb_q.size(), 100);
        for (int i = 0; i < 100 && lb_q.size() > 0; i++) begin
            chk($sformatf("lb_w%0d", i), lb_q.pop_front(), sent[i]);
            chk($sformatf("lb_n%0d", i), lb_nq.pop_front(), 16);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
